// File: rtl/sd_window_pkg.sv
// Shared types for the sigma-delta acquisition-window controller.
// Imported by the RTL, the readout-side sync logic and the testbench.
package sd_window_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    COUNT = 2'd2,
    LATCH = 2'd3
  } sd_win_state_t;

endpackage

// File: rtl/sd_window_ctrl_gray_counter.sv
// Ones counter with a gray-coded output. Async reset for power-on,
// synchronous clear so the controller can restart a window without glitching rst.
module gray_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             enable,
  output logic [WIDTH-1:0] gray
);

  logic [WIDTH-1:0] bin_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q <= '0;
    end else if (clr) begin
      bin_q <= '0;
    end else if (enable) begin
      bin_q <= bin_q + WIDTH'(1);
    end
  end

  assign gray = bin_q ^ (bin_q >> 1);

endmodule

// File: rtl/sd_window_ctrl.sv
// Acquisition-window controller: counts modulator ones over N cycles and
// hands the gray-coded result to a single-entry valid/ready output register.
module sd_window_ctrl
  import sd_window_pkg::*;
#(
  parameter int BIT_COUNT    = 16,
  parameter int WINDOW_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    continuous,
  input  logic [WINDOW_WIDTH-1:0] window_len,
  input  logic                    sd_bit,
  input  logic                    sample_ready,
  output logic [BIT_COUNT-1:0]    sample_gray,
  output logic                    sample_valid,
  output logic                    busy,
  output logic                    overrun,
  output sd_win_state_t           state
);

  // Output handshake: a transfer happens on any cycle with sample_valid &
  // sample_ready; sample_gray holds steady while sample_valid is high, and
  // sample_valid is driven only from flops (no path from sample_ready).

  sd_win_state_t           state_q, state_d;
  logic [WINDOW_WIDTH-1:0] len_q;
  logic [WINDOW_WIDTH-1:0] win_q;
  logic                    cont_q;
  logic                    accept, load, drop;
  logic [BIT_COUNT-1:0]    cnt_gray;

  gray_counter #(.WIDTH(BIT_COUNT)) u_ones (
    .clk    (clk),
    .rst    (reset),
    .clr    (state_q == CLEAR),
    .enable ((state_q == COUNT) && sd_bit),
    .gray   (cnt_gray)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    load    = 1'b0;
    drop    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !stop && (window_len != '0)) begin
          accept  = 1'b1;
          state_d = CLEAR;
        end
      end
      CLEAR: state_d = stop ? IDLE : COUNT;
      COUNT: begin
        if (stop)             state_d = IDLE;
        else if (win_q == '0) state_d = LATCH;
      end
      LATCH: begin
        if (stop) begin
          state_d = IDLE;
        end else begin
          // A sample draining this very cycle frees the slot for the new one.
          if (!sample_valid || sample_ready) load = 1'b1;
          else                               drop = 1'b1;
          state_d = cont_q ? CLEAR : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_q        <= '0;
      cont_q       <= 1'b0;
      win_q        <= '0;
      sample_gray  <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      busy <= (state_d != IDLE);
      if (accept) begin
        len_q  <= window_len;
        cont_q <= continuous;
      end
      if (state_q == CLEAR)      win_q <= len_q - WINDOW_WIDTH'(1);
      else if (state_q == COUNT) win_q <= win_q - WINDOW_WIDTH'(1);
      if (load) begin
        sample_gray  <= cnt_gray;
        sample_valid <= 1'b1;
      end else if (sample_valid && sample_ready) begin
        sample_valid <= 1'b0;
      end
      if (accept)    overrun <= 1'b0;
      else if (drop) overrun <= 1'b1;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_sd_window_ctrl.sv
// Self-checking bench for sd_window_ctrl: directed scenarios plus random
// traffic, compared cycle by cycle with a window-position reference model.
module tb_sd_window_ctrl;
  import sd_window_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, stop, continuous, sd_bit, sample_ready;
  logic [15:0] window_len;
  logic [15:0] sample_gray;
  logic        sample_valid, busy, overrun;
  sd_win_state_t dbg_state;

  sd_window_ctrl #(.BIT_COUNT(16), .WINDOW_WIDTH(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .stop         (stop),
    .continuous   (continuous),
    .window_len   (window_len),
    .sd_bit       (sd_bit),
    .sample_ready (sample_ready),
    .sample_gray  (sample_gray),
    .sample_valid (sample_valid),
    .busy         (busy),
    .overrun      (overrun),
    .state        (dbg_state)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a window is a sequence of positions 0 (clear),
  // 1..len (counting), len+1 (latch); samples are gray(count of ones).
  bit          m_active;
  int          m_pos, m_len, m_ones, n_xfer;
  bit          m_cont, m_valid, m_over;
  logic [15:0] m_data;
  logic [15:0] exp_q[$];

  function automatic logic [15:0] to_gray(input int b);
    return 16'(b ^ (b >> 1));
  endfunction

  task automatic model_reset();
    m_active = 0; m_pos = 0; m_len = 0; m_ones = 0;
    m_cont = 0; m_valid = 0; m_over = 0; m_data = '0;
    exp_q.delete();
  endtask

  task automatic model_step();
    bit xfer, ld;
    xfer = m_valid && sample_ready;
    ld   = 0;
    if (xfer) begin
      n_xfer++;
      if (exp_q.size() == 0) check("xfer_unexpected", 32'(sample_gray), 32'hdead);
      else                   check("xfer_data", 32'(sample_gray), 32'(exp_q.pop_front()));
    end
    if (!m_active) begin
      if (start && !stop && window_len != 0) begin
        m_active = 1; m_pos = 0; m_len = window_len;
        m_cont = continuous; m_over = 0;
      end
    end else if (stop) begin
      m_active = 0;
    end else if (m_pos == 0) begin
      m_ones = 0; m_pos = 1;
    end else if (m_pos <= m_len) begin
      m_ones += int'(sd_bit); m_pos++;
    end else begin
      if (!m_valid || xfer) begin
        ld = 1; m_data = to_gray(m_ones); exp_q.push_back(m_data);
      end else begin
        m_over = 1;
      end
      if (m_cont) m_pos = 0;
      else        m_active = 0;
    end
    if (ld)        m_valid = 1;
    else if (xfer) m_valid = 0;
  endtask

  task automatic compare_all();
    check("valid",   32'(sample_valid), 32'(m_valid));
    check("gray",    32'(sample_gray),  32'(m_data));
    check("busy",    32'(busy),         32'(m_active));
    check("overrun", 32'(overrun),      32'(m_over));
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk); #1;
    compare_all();
  endtask

  task automatic set_in(input bit st, input bit sp, input bit ct, input int len,
                        input bit sd, input bit rdy);
    start = st; stop = sp; continuous = ct; window_len = 16'(len);
    sd_bit = sd; sample_ready = rdy;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) begin
      set_in(0, 0, 0, 0, 0, rdy);
      cycle();
    end
  endtask

  initial begin
    int x0;
    reset = 1'b1;
    set_in(0, 0, 0, 0, 0, 0);
    n_xfer = 0;
    model_reset();
    #12;
    check("rst_valid", 32'(sample_valid), 32'd0);
    check("rst_gray",  32'(sample_gray),  32'd0);
    check("rst_busy",  32'(busy),         32'd0);
    check("rst_state", 32'(dbg_state),    32'(IDLE));
    @(posedge clk); #1;
    reset = 1'b0;

    // Single window, N=8, ones on cycles 2..6
    set_in(1, 0, 0, 8, 0, 0);
    cycle();
    for (int k = 1; k <= 12; k++) begin
      set_in(0, 0, 0, 0, (k >= 2 && k <= 6), 0);
      cycle();
      if (k == 9)  check("t1_no_valid_early", 32'(sample_valid), 32'd0);
      if (k == 10) begin
        check("t1_valid", 32'(sample_valid), 32'd1);
        check("t1_gray",  32'(sample_gray),  32'h0007);
        check("t1_busy",  32'(busy),         32'd0);
      end
    end
    idle(2, 1);

    // Continuous, no backpressure: N=4, sd_bit=1
    x0 = n_xfer;
    set_in(1, 0, 1, 4, 1, 1);
    cycle();
    for (int k = 0; k < 30; k++) begin
      set_in(0, 0, 0, 0, 1, 1);
      cycle();
      if (sample_valid) check("t2_gray", 32'(sample_gray), 32'h0006);
    end
    check("t2_overrun", 32'(overrun), 32'd0);
    set_in(0, 1, 0, 0, 1, 1);
    cycle();
    idle(2, 1);
    check("t2_samples", 32'(n_xfer - x0), 32'd5);

    // Overrun: N=2 continuous, no ready
    set_in(1, 0, 1, 2, 1, 0);
    cycle();
    for (int k = 0; k < 12; k++) begin
      set_in(0, 0, 0, 0, 1, 0);
      cycle();
    end
    check("t3_overrun", 32'(overrun), 32'd1);
    check("t3_gray",    32'(sample_gray), 32'h0003);
    set_in(0, 1, 0, 0, 1, 0);
    cycle();
    x0 = n_xfer;
    idle(3, 1);
    check("t3_once", 32'(n_xfer - x0), 32'd1);

    // Coincident drain: ready only on LATCH cycles
    set_in(1, 0, 1, 3, 1, 0);
    cycle();
    for (int k = 0; k < 20; k++) begin
      set_in(0, 0, 0, 0, 1, (m_active && m_pos == m_len + 1));
      cycle();
    end
    check("t4_overrun", 32'(overrun), 32'd0);
    check("t4_valid",   32'(sample_valid), 32'd1);
    set_in(0, 1, 0, 0, 0, 1);
    cycle();
    idle(2, 1);

    // Stop mid-COUNT
    set_in(1, 0, 0, 10, 1, 0);
    cycle();
    for (int k = 0; k < 4; k++) begin
      set_in(0, 0, 0, 0, 1, 0);
      cycle();
    end
    set_in(0, 1, 0, 0, 1, 0);
    cycle();
    check("t5_stop_busy",  32'(busy), 32'd0);
    check("t5_stop_valid", 32'(sample_valid), 32'd0);
    // start with zero length, and start with stop
    set_in(1, 0, 0, 0, 1, 0);
    cycle();
    check("t5_len0_busy", 32'(busy), 32'd0);
    set_in(1, 1, 0, 5, 1, 0);
    cycle();
    check("t5_startstop_busy", 32'(dbg_state), 32'(IDLE));
    idle(1, 0);

    // Asynchronous reset mid-COUNT
    set_in(1, 0, 0, 6, 1, 0);
    cycle();
    for (int k = 0; k < 3; k++) begin
      set_in(0, 0, 0, 0, 1, 0);
      cycle();
    end
    #3 reset = 1'b1;
    #1;
    check("t6_rst_busy",  32'(busy), 32'd0);
    check("t6_rst_valid", 32'(sample_valid), 32'd0);
    check("t6_rst_state", 32'(dbg_state), 32'(IDLE));
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    set_in(1, 0, 0, 3, 1, 0);
    cycle();
    for (int k = 0; k < 6; k++) begin
      set_in(0, 0, 0, 0, 1, 0);
      cycle();
    end
    check("t6_gray",  32'(sample_gray), 32'h0002);
    check("t6_valid", 32'(sample_valid), 32'd1);
    idle(2, 1);

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      set_in(($urandom_range(0, 7) == 0), ($urandom_range(0, 29) == 0),
             $urandom_range(0, 1), $urandom_range(0, 6),
             $urandom_range(0, 1), ($urandom_range(0, 2) != 0));
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
